// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage MIPS pipeline. Resolves load-use, branch,
//   jump, instruction-fetch wait and data-memory wait into PC write-enable and per-register
//   hold/flush/bubble controls. A small FSM tracks whether an outstanding fetch was made stale
//   by a redirect, so the word that eventually returns for the old PC is dropped.
//
// Ports
//   clk, reset            clock (rising edge), synchronous active-high reset
//   id_rs, id_rt          source registers of the instruction in ID
//   id_uses_rt            ID instruction reads rt
//   ex_mem_read, ex_rt    EX instruction is a load, and its destination
//   ex_branch_taken       branch resolved taken in EX
//   id_jump               jump decoded in ID
//   imem_ready            fetch data for the current PC is valid
//   mem_access            MEM instruction accesses data memory
//   dmem_ready            data memory completes this cycle
//   pc_write              PC load enable
//   if_id_hold/flush      IF/ID hold / load NOP
//   id_ex_bubble/hold     ID/EX load zero / hold
//   ex_mem_hold           EX/MEM hold
//   mem_wb_bubble         MEM/WB load zero
//   stall_cycles          saturating count of non-reset cycles with pc_write low
//   flush_count           saturating count of branch/jump redirect flushes
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             id_jump,
    input  logic             imem_ready,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_hold,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             id_ex_hold,
    output logic             ex_mem_hold,
    output logic             mem_wb_bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {StRun, StIwait, StIwaitDiscard} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             freeze, load_use, redirect, flush_fire;

    always_comb begin
        freeze     = mem_access & ~dmem_ready;
        load_use   = ex_mem_read & (ex_rt != 5'd0) &
                     ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
        // A memory freeze holds EX, so a branch/jump seen there is not acted on yet.
        redirect   = ~freeze & (ex_branch_taken | id_jump);
        flush_fire = ~reset & redirect;
    end

    // Control outputs: fixed priority, first match wins.
    always_comb begin
        pc_write      = 1'b0;
        if_id_hold    = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        id_ex_hold    = 1'b0;
        ex_mem_hold   = 1'b0;
        mem_wb_bubble = 1'b0;
        if (reset) begin
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (freeze) begin
            if_id_hold    = 1'b1;
            id_ex_hold    = 1'b1;
            ex_mem_hold   = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            pc_write     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (id_jump) begin
            pc_write    = 1'b1;
            if_id_flush = 1'b1;
        end else if (load_use) begin
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (state_q == StIwaitDiscard) begin
            // Whatever arrives belongs to the pre-redirect PC.
            if_id_flush = 1'b1;
        end else if (!imem_ready) begin
            if_id_flush = 1'b1;
        end else begin
            pc_write = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!freeze) begin
            case (state_q)
                StRun: begin
                    if (!imem_ready) state_d = redirect ? StIwaitDiscard : StIwait;
                end
                StIwait: begin
                    if (imem_ready)    state_d = StRun;
                    else if (redirect) state_d = StIwaitDiscard;
                end
                StIwaitDiscard: begin
                    // Stale word returned; the redirect target fetch starts next cycle.
                    if (imem_ready) state_d = StIwait;
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            if (!pc_write && stall_q != CntMax) stall_q <= stall_q + CNT_W'(1);
            if (flush_fire && flush_q != CntMax) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl: a vector table for single-cycle decode cases
// plus hand sequences for the fetch-wait FSM, memory freeze and counter saturation. A second
// instance with CNT_W=4 shares all inputs and is used for the saturation checks.
module tb_pipeline_hazard_ctrl;

    typedef struct {
        string      name;
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mem_read;
        logic [4:0] ex_rt;
        logic       br;
        logic       jmp;
        logic       imem;
        logic       macc;
        logic       drdy;
        logic [6:0] exp;   // {pc_write, if_id_hold, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_hold, mem_wb_bubble}
        logic       finc;  // expected flush_count increment
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
    logic        id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0, id_jump = 1'b0;
    logic        imem_ready = 1'b1, mem_access = 1'b0, dmem_ready = 1'b1;

    logic        pc_write, if_id_hold, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_hold;
    logic        mem_wb_bubble;
    logic [15:0] stall_cycles, flush_count;
    logic        pc_write4, if_id_hold4, if_id_flush4, id_ex_bubble4, id_ex_hold4, ex_mem_hold4;
    logic        mem_wb_bubble4;
    logic [3:0]  stall_cycles4, flush_count4;

    int checks = 0;
    int failures = 0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .id_jump(id_jump), .imem_ready(imem_ready), .mem_access(mem_access),
        .dmem_ready(dmem_ready), .pc_write(pc_write), .if_id_hold(if_id_hold),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .id_ex_hold(id_ex_hold),
        .ex_mem_hold(ex_mem_hold), .mem_wb_bubble(mem_wb_bubble),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .id_jump(id_jump), .imem_ready(imem_ready), .mem_access(mem_access),
        .dmem_ready(dmem_ready), .pc_write(pc_write4), .if_id_hold(if_id_hold4),
        .if_id_flush(if_id_flush4), .id_ex_bubble(id_ex_bubble4), .id_ex_hold(id_ex_hold4),
        .ex_mem_hold(ex_mem_hold4), .mem_wb_bubble(mem_wb_bubble4),
        .stall_cycles(stall_cycles4), .flush_count(flush_count4)
    );

    wire [6:0] act  = {pc_write, if_id_hold, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_hold,
                       mem_wb_bubble};
    wire [6:0] act4 = {pc_write4, if_id_hold4, if_id_flush4, id_ex_bubble4, id_ex_hold4,
                       ex_mem_hold4, mem_wb_bubble4};

    function automatic vec_t mk(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                                input logic uses_rt, input logic mem_read,
                                input logic [4:0] ert, input logic br, input logic jmp,
                                input logic macc, input logic drdy, input logic [6:0] exp,
                                input logic finc);
        vec_t v;
        v.name = nm; v.rst = 1'b0; v.rs = rs; v.rt = rt; v.uses_rt = uses_rt;
        v.mem_read = mem_read; v.ex_rt = ert; v.br = br; v.jmp = jmp; v.imem = 1'b1;
        v.macc = macc; v.drdy = drdy; v.exp = exp; v.finc = finc;
        return v;
    endfunction

    // Control-only vector: no load hazard possible.
    function automatic vec_t ctl(input string nm, input logic rst, input logic br,
                                 input logic jmp, input logic imem, input logic macc,
                                 input logic drdy, input logic [6:0] exp, input logic finc);
        vec_t v;
        v = mk(nm, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, br, jmp, macc, drdy, exp, finc);
        v.rst = rst;
        v.imem = imem;
        return v;
    endfunction

    function automatic int sat4(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    task automatic run(input vec_t v);
        reset = v.rst; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt;
        ex_mem_read = v.mem_read; ex_rt = v.ex_rt; ex_branch_taken = v.br; id_jump = v.jmp;
        imem_ready = v.imem; mem_access = v.macc; dmem_ready = v.drdy;
        @(negedge clk);
        checks++;
        if (act !== v.exp) begin
            failures++;
            $display("FAIL %s outputs: got %b want %b", v.name, act, v.exp);
        end
        checks++;
        if (act4 !== v.exp) begin
            failures++;
            $display("FAIL %s outputs(w4): got %b want %b", v.name, act4, v.exp);
        end
        if (v.rst) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (!v.exp[6]) m_stall++;
            if (v.finc) m_flush++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (stall_cycles !== 16'(m_stall) || flush_count !== 16'(m_flush)) begin
            failures++;
            $display("FAIL %s counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     v.name, stall_cycles, flush_count, m_stall, m_flush);
        end
        checks++;
        if (stall_cycles4 !== 4'(sat4(m_stall)) || flush_count4 !== 4'(sat4(m_flush))) begin
            failures++;
            $display("FAIL %s counters(w4): got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     v.name, stall_cycles4, flush_count4, sat4(m_stall), sat4(m_flush));
        end
    endtask

    vec_t tbl[14];

    initial begin
        //          name          rs     rt     urt   mrd   ert    br    jmp   macc  drdy  expected      finc
        tbl[0]  = mk("plain",     5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 7'b1000000, 1'b0);
        tbl[1]  = mk("lu_rs",     5'd8,  5'd2,  1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, 1'b1, 7'b0101000, 1'b0);
        tbl[2]  = mk("lu_r0",     5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 7'b1000000, 1'b0);
        tbl[3]  = mk("lu_rt",     5'd3,  5'd9,  1'b1, 1'b1, 5'd9,  1'b0, 1'b0, 1'b0, 1'b1, 7'b0101000, 1'b0);
        tbl[4]  = mk("rt_unused", 5'd3,  5'd9,  1'b0, 1'b1, 5'd9,  1'b0, 1'b0, 1'b0, 1'b1, 7'b1000000, 1'b0);
        tbl[5]  = mk("no_load",   5'd8,  5'd2,  1'b0, 1'b0, 5'd8,  1'b0, 1'b0, 1'b0, 1'b1, 7'b1000000, 1'b0);
        tbl[6]  = mk("lu_br",     5'd8,  5'd2,  1'b0, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 1'b1, 7'b1011000, 1'b1);
        tbl[7]  = mk("jump",      5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 7'b1010000, 1'b1);
        tbl[8]  = mk("br_jump",   5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 7'b1011000, 1'b1);
        tbl[9]  = mk("lu_jump",   5'd7,  5'd2,  1'b0, 1'b1, 5'd7,  1'b0, 1'b1, 1'b0, 1'b1, 7'b1010000, 1'b1);
        tbl[10] = mk("frz_br",    5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 7'b0100111, 1'b0);
        tbl[11] = mk("frz_lu",    5'd8,  5'd2,  1'b0, 1'b1, 5'd8,  1'b0, 1'b1, 1'b1, 1'b0, 7'b0100111, 1'b0);
        tbl[12] = mk("mem_done",  5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 7'b1000000, 1'b0);
        tbl[13] = mk("drdy_only", 5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 7'b1000000, 1'b0);

        #1;
        run(ctl("reset", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'b0011001, 1'b0));
        run(ctl("reset2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0011001, 1'b0));

        for (int i = 0; i < 14; i++) run(tbl[i]);

        // Fetch wait from RUN: three flushed cycles, then normal.
        for (int i = 0; i < 3; i++)
            run(ctl("iwait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0010000, 1'b0));
        run(ctl("iwait_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'b1000000, 1'b0));

        // Jump while in IWAIT: the returning word is stale and must be discarded.
        run(ctl("to_iwait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0010000, 1'b0));
        run(ctl("iw_jump", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'b1010000, 1'b1));
        run(ctl("disc_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0010000, 1'b0));
        run(ctl("disc_drop", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'b0010000, 1'b0));
        run(ctl("disc_iwait", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'b1000000, 1'b0));
        run(ctl("disc_run", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'b1000000, 1'b0));

        // Branch with fetch pending from RUN, then a second redirect while discarding.
        run(ctl("run_br_wait", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1011000, 1'b1));
        run(ctl("disc_jump", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'b1010000, 1'b1));
        run(ctl("disc_drop2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'b0010000, 1'b0));
        run(ctl("disc_iwait2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'b1000000, 1'b0));

        // Data-memory freeze masks a taken branch for four cycles.
        for (int i = 0; i < 4; i++)
            run(ctl("freeze_br", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7'b0100111, 1'b0));
        run(ctl("unfreeze_br", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 7'b1011000, 1'b1));

        // Reset out of IWAIT_DISCARD returns to RUN with cleared counters.
        run(ctl("to_disc", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1011000, 1'b1));
        run(ctl("rst_disc", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'b0011001, 1'b0));
        run(ctl("post_rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'b1000000, 1'b0));

        // Saturation: 20 stall cycles, then 20 jump flushes.
        for (int i = 0; i < 20; i++)
            run(ctl("sat_stall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0010000, 1'b0));
        run(ctl("rst_sat", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'b0011001, 1'b0));
        for (int i = 0; i < 20; i++)
            run(ctl("sat_flush", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 7'b1010000, 1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
